// File: rtl/vga_pkg.sv
// vga_pkg -- shared VGA timing constants, VRAM layout and arbiter types.
//
// Holds the 640x480@60 timing constants, the VRAM words-per-line figure,
// the CPU-side FSM state enum and the registered VRAM command struct used by
// vram_arbiter and vram_slot_gen. No ports; imported with vga_pkg::*.
package vga_pkg;

    // Horizontal timing, in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = 800;

    // Vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = 525;

    // Two RGB332 pixels per 16-bit word: 640 / 2 words per line
    localparam int WORDS_PER_LINE = 320;

    localparam int POS_W  = 11;
    localparam int ADDR_W = 17;
    localparam int DATA_W = 16;
    localparam int PIX_W  = 8;

    typedef enum logic [1:0] {
        CPU_IDLE  = 2'd0,
        CPU_GRANT = 2'd1,
        CPU_ACK   = 2'd2
    } cpu_state_t;

    // One registered VRAM port command (valid for the cycle after the edge)
    typedef struct packed {
        logic              oe;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Word address of pixel (px, py): py*320 + px/2. The full frame needs
    // 153600 words, more than 17 bits cover, so the upper lines alias; the
    // product is formed at 20 bits and truncated to the port width.
    function automatic logic [ADDR_W-1:0] vram_word_addr(
        input logic [POS_W-1:0] px,
        input logic [POS_W-1:0] py
    );
        logic [19:0] a;
        a = 20'(py) * 20'(WORDS_PER_LINE) + 20'(px[POS_W-1:1]);
        return a[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/vram_slot_gen.sv
// vram_slot_gen -- fetch-position and slot decode for the VRAM arbiter.
//
// Ports:
//   x, y       in   current pixel position from the timing generator
//   fx, fy     out  fetch position: (x, y) advanced by 2 pixel clocks,
//                   wrapping at H_TOTAL and then V_TOTAL
//   disp_slot  out  1 when this cycle belongs to the display fetch
//                   (fx even, fx < H_ACTIVE, fy < V_ACTIVE)
// Purely combinational.
module vram_slot_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL
) (
    input  logic [POS_W-1:0] x,
    input  logic [POS_W-1:0] y,
    output logic [POS_W-1:0] fx,
    output logic [POS_W-1:0] fy,
    output logic             disp_slot
);

    logic [POS_W:0] hx;

    always_comb begin
        hx = {1'b0, x} + (POS_W+1)'(2);
        fx = hx[POS_W-1:0];
        fy = y;
        if (hx >= (POS_W+1)'(H_TOTAL)) begin
            fx = POS_W'(hx - (POS_W+1)'(H_TOTAL));
            if (({1'b0, y} + (POS_W+1)'(1)) >= (POS_W+1)'(V_TOTAL))
                fy = '0;
            else
                fy = y + POS_W'(1);
        end
    end

    // Odd fetch columns are left to the CPU: each display word covers two
    // pixels, so one read every other clock keeps the line fed.
    assign disp_slot = ~fx[0] && (fx < POS_W'(H_ACTIVE)) && (fy < POS_W'(V_ACTIVE));

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter -- single-port VRAM shared between display refresh and CPU.
//
// All state changes on the falling edge of clk; rst is asynchronous,
// active-low. Display fetches own every even fetch column in the active
// area; the CPU gets all remaining cycles through an IDLE/GRANT/ACK FSM.
//
// Ports:
//   clk, rst                    pixel clock, async active-low reset
//   x, y                        current pixel position
//   cpu_req/we/addr/wdata       CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack          read data and one-cycle completion pulse
//   mem_addr/wdata/we/oe        VRAM port (registered)
//   mem_rdata                   VRAM read data, one cycle after mem_oe
//   pix                         RGB332 pixel for the sampled (x, y)
//   cpu_stall_cnt               CPU wait-cycle counter
//
// Optional feature: define VRAM_STALL_CNT_EN to build the saturating
// stall counter; otherwise cpu_stall_cnt is tied to 0.
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_TOTAL  = VGA_V_TOTAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  x,
    input  logic [POS_W-1:0]  y,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PIX_W-1:0]  pix,
    output logic [DATA_W-1:0] cpu_stall_cnt
);

    // Fetch issued at edge n is on the port during cycle n, the VRAM
    // returns it during cycle n+1, and it is consumed at edge n+2.
    localparam int STAGES = 2;

    logic [POS_W-1:0]  fx, fy;
    logic              disp_slot;
    cpu_state_t        state;
    logic              grant;
    logic              rd_pend;     // access in flight is a read
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] pix_word;
    logic [DATA_W-1:0] cur_word;
    logic              active;
    logic [STAGES:1]   vld_pipe;
    mem_cmd_t          cmd_q;

    vram_slot_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_TOTAL  (H_TOTAL),
        .V_ACTIVE (V_ACTIVE),
        .V_TOTAL  (V_TOTAL)
    ) u_slot (
        .x         (x),
        .y         (y),
        .fx        (fx),
        .fy        (fy),
        .disp_slot (disp_slot)
    );

    // The display never yields; a CPU request only starts from IDLE in a
    // non-display cycle, so in the active area it waits at most one clock.
    assign grant = (state == CPU_IDLE) && cpu_req && !disp_slot;

    // ------------------------------------------------------------------
    // CPU FSM
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CPU_IDLE;
            rd_pend <= 1'b0;
        end else begin
            case (state)
                CPU_IDLE: begin
                    if (grant) begin
                        state   <= CPU_GRANT;
                        rd_pend <= ~cpu_we;
                    end
                end
                CPU_GRANT: state <= CPU_ACK;
                CPU_ACK:   state <= CPU_IDLE;   // cpu_req deliberately ignored
                default:   state <= CPU_IDLE;
            endcase
        end
    end

    assign cpu_ack = (state == CPU_ACK);

    // Read data lands on mem_rdata during the ACK cycle; pass it straight
    // through then and hold it afterwards. Writes leave it untouched.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            rdata_q <= '0;
        else if (state == CPU_ACK && rd_pend)
            rdata_q <= mem_rdata;
    end

    assign cpu_rdata = (cpu_ack && rd_pend) ? mem_rdata : rdata_q;

    // ------------------------------------------------------------------
    // VRAM port command
    // ------------------------------------------------------------------
    // Address and write data hold their last value when idle; only the
    // strobes are dropped.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q <= '0;
        end else if (disp_slot) begin
            cmd_q.oe   <= 1'b1;
            cmd_q.we   <= 1'b0;
            cmd_q.addr <= vram_word_addr(fx, fy);
        end else if (grant) begin
            cmd_q.oe    <= ~cpu_we;
            cmd_q.we    <= cpu_we;
            cmd_q.addr  <= cpu_addr;
            cmd_q.wdata <= cpu_wdata;
        end else begin
            cmd_q.oe <= 1'b0;
            cmd_q.we <= 1'b0;
        end
    end

    assign mem_oe    = cmd_q.oe;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

    // ------------------------------------------------------------------
    // Pixel path
    // ------------------------------------------------------------------
    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[STAGES-1:1], disp_slot};
    end

    // The word fetched for an even column arrives exactly as that column is
    // sampled, so the low byte bypasses the register; the odd column that
    // follows reads the high byte back from it.
    assign cur_word = vld_pipe[STAGES] ? mem_rdata : pix_word;
    assign active   = (x < POS_W'(H_ACTIVE)) && (y < POS_W'(V_ACTIVE));

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            pix_word <= '0;
            pix      <= '0;
        end else begin
            if (vld_pipe[STAGES])
                pix_word <= mem_rdata;
            if (active)
                pix <= x[0] ? cur_word[15:8] : cur_word[7:0];
            else
                pix <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------
`ifdef VRAM_STALL_CNT_EN
    logic [DATA_W-1:0] stall_q;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            stall_q <= '0;
        else if ((state == CPU_IDLE) && cpu_req && !grant && (stall_q != '1))
            stall_q <= stall_q + DATA_W'(1);
    end

    assign cpu_stall_cnt = stall_q;
`else
    assign cpu_stall_cnt = '0;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, visible pixels per line; H_TOTAL 800, pixel clocks per line; V_ACTIVE 480, visible lines; V_TOTAL 525, lines per frame.
REQ-002 clk  input  1  pixel clock (~25.175 MHz); all logic on negedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 x, y  input  11 each  current pixel position from the timing generator.
REQ-005 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-006 cpu_we  input  1  1 = write, 0 = read; held with cpu_req.
REQ-007 cpu_addr  input  17  word address; cpu_wdata  input  16  write data.
REQ-008 cpu_rdata  output  16  read data, valid with cpu_ack.
REQ-009 cpu_ack  output  1  one-cycle completion pulse.
REQ-010 mem_addr  output  17; mem_wdata  output  16; mem_we  output  1; mem_oe  output  1: VRAM port, read data returned on mem_rdata  input  16 one cycle after mem_oe.
REQ-011 pix  output  8  RGB332 pixel for the current (x, y); 0 outside the active area.
REQ-012 cpu_stall_cnt  output  16  CPU wait-cycle counter (see Configuration).

Function
REQ-013 Each VRAM word SHALL hold two pixels: bits [7:0] = even x, bits [15:8] = odd x; word address = y*320 + x/2.
REQ-014 Fetch position (fx, fy) SHALL be (x, y) advanced by 2 pixel clocks, wrapping at H_TOTAL and then V_TOTAL.
REQ-015 A cycle SHALL be a display slot when fx is even, fx < H_ACTIVE and fy < V_ACTIVE; every other cycle SHALL be a CPU slot.
REQ-016 In a display slot the block SHALL drive mem_oe=1, mem_we=0 and mem_addr = fy*320 + fx/2; the display always wins.
REQ-017 The returned word SHALL be latched into a 16-bit pixel register; pix SHALL be registered, showing the low byte at even x and the high byte at odd x, exactly aligned to (x, y).
REQ-018 CPU FSM states: IDLE, GRANT, ACK.
REQ-019 IDLE -> GRANT when cpu_req=1 in a CPU slot; VRAM driven with cpu_addr, mem_we=cpu_we, mem_oe=~cpu_we, mem_wdata=cpu_wdata during GRANT.
REQ-020 GRANT -> ACK unconditionally; in ACK, cpu_ack=1 and cpu_rdata = mem_rdata (read) or unchanged (write).
REQ-021 ACK -> IDLE unconditionally; cpu_req SHALL be ignored in the ACK cycle.
REQ-022 A request arriving in a display slot SHALL wait in IDLE; the worst-case grant latency is 1 cycle in the active area and 0 cycles in blanking.
REQ-023 In a cycle with no access, mem_we=0 and mem_oe=0.
REQ-024 x=H_TOTAL-2 on line V_TOTAL-1 SHALL fetch word 0 of frame line 0 (wrap correctness).

Reset
REQ-025 While rst=0: FSM=IDLE; cpu_ack=0, cpu_rdata=0, pix=0, pixel register=0, mem_we=0, mem_oe=0, mem_addr=0, mem_wdata=0, cpu_stall_cnt=0.
REQ-026 Reset during GRANT SHALL abort the access with no ack; the next request after release is served normally.

Configuration
REQ-027 With VRAM_STALL_CNT_EN defined, cpu_stall_cnt SHALL increment, saturating at 16'hFFFF, each cycle cpu_req=1 while FSM=IDLE and no grant is given; it is cleared only by reset.
REQ-028 Without VRAM_STALL_CNT_EN, cpu_stall_cnt SHALL be constant 0 and no counter logic is built.

Structure
REQ-029 The timing constants (640/16/96/48/800, 480/10/2/33/525), the words-per-line constant 320 and the FSM state enum SHALL live in shared package vga_pkg.
REQ-030 The fetch-position and slot decode SHALL be sub-module vram_slot_gen (inputs x, y; outputs fx, fy, disp_slot); the arbiter FSM and pixel path stay in vram_arbiter.

Verification
REQ-031 Blanking (y=500): cpu_req write addr 0x00010 data 0xABCD -> mem_we=1 the same cycle, cpu_ack the next cycle, total 2 cycles.
REQ-032 Active area: read request raised when fx is even -> the grant is delayed exactly 1 cycle; cpu_rdata equals the previously written 0xABCD at ack.
REQ-033 Preload word 0 = 0x3412, word 1 = 0x7856, sweep line 0 -> pix = 0x12, 0x34, 0x56, 0x78 at x = 0..3, and pix=0 at x >= 640.
REQ-034 Continuous cpu_req across a full active line -> no display fetch is ever missed, every CPU access is acked, and mem_we is never 1 in a display slot.
REQ-035 rst pulled low during GRANT -> no cpu_ack; all outputs at reset values; with VRAM_STALL_CNT_EN, cpu_stall_cnt=0 after reset.
REQ-036 Frame wrap (y=524, x=798) -> mem_addr=0 with mem_oe=1.
